ppu_vram_arbiter: RTL and testbench
===================================

# ppu_vram_arbiter

Shares the single PPU video-memory bus between the scanline renderer's fetch port and the CPU-side PPUDATA access port. Decodes the 14-bit PPU address space into CHR (pattern), CIRAM (nametable, with mirroring) and palette selects. The renderer always has priority. CPU accesses are buffered, issued only in bus gaps, and retried if the renderer preempts them. Sits between the renderer, the PPU register file and the video memories.

## Interface
- CHR_RAM, 0: 1 = CHR region writable; 0 = CHR writes dropped, still acknowledged.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ren_busy  in  1  renderer owns the bus this cycle (level).
- ren_addr  in  16  renderer VRAM address.
- ren_data  out  8  read data to renderer; equals mem_rdata.
- cpu_req  in  1  one-cycle request strobe.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  16  CPU-side VRAM address; sampled with cpu_req.
- cpu_wdata  in  8  write data; sampled with cpu_req.
- cpu_busy  out  1  request buffered or in flight.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read result; valid while cpu_ack = 1, held until the next read completes.
- cpu_overrun  out  1  sticky; set when cpu_req arrives while cpu_busy = 1; cleared only by reset.
- mirror_v  in  1  1 = vertical mirroring, 0 = horizontal.
- mem_sel  out  2  00 CHR, 01 CIRAM, 10 palette, 11 none.
- mem_addr  out  13  physical address inside the selected memory.
- mem_we  out  1  write enable.
- mem_wdata  out  8  write data.
- mem_rdata  in  8  memory read data; synchronous, valid one cycle after the address.

## Operation
- Decode uses a[13:0] of the winning address; bits 15:14 are ignored.
  - 0x0000–0x1FFF: CHR, mem_addr = a[12:0].
  - 0x2000–0x3EFF: CIRAM, mem_addr = {2'b0, A10, a[9:0]}; A10 = a[10] if mirror_v, else a[11]. The 0x3000 range aliases 0x2000.
  - 0x3F00–0x3FFF: palette, mem_addr = {8'b0, p[4:0]}. p = a[4:0], except when a[4] = 1 and a[1:0] = 00, then p = {1'b0, a[3:0]}.
- Mux: when ren_busy = 1, the decoded ren_addr drives the bus and mem_we = 0, regardless of CPU state. Otherwise the CPU FSM drives the bus. In IDLE with no CPU activity, mem_sel = 11.
- ren_data is a combinational passthrough of mem_rdata. The renderer's two-cycle address/sample fetch pattern covers the memory latency.
- CPU FSM states: IDLE, ADDR, DATA, ACK.
  - IDLE: on cpu_req, latch we/addr/wdata and set cpu_busy. Go to ADDR.
  - ADDR: drive the decoded latched address. mem_we = latched we, except 0 for CHR when CHR_RAM = 0. If ren_busy = 1, stay in ADDR; no write is issued.
    - Write: go to ACK.
    - Read: go to DATA.
  - DATA (reads only): hold the address. If ren_busy = 0, capture mem_rdata into cpu_rdata and go to ACK. If ren_busy = 1, return to ADDR (retry).
  - ACK: cpu_ack = 1 for one cycle, cpu_busy cleared, go to IDLE. A cpu_req in the ACK cycle counts as an overrun and is dropped.
- cpu_req while cpu_busy = 1: ignored and cpu_overrun set.

## Timing
- Reset values: state IDLE, cpu_busy 0, cpu_ack 0, cpu_rdata 0x00, cpu_overrun 0, mem_we 0, mem_sel 11, mem_addr 0, mem_wdata 0. Reset mid-access abandons the access with no ack. A write is only committed on a clock edge with mem_we = 1.
- Uncontended latency, from the cpu_req edge to cpu_ack high:
  - Write: 2 cycles (ADDR, ACK).
  - Read: 3 cycles (ADDR, DATA, ACK).
- Each preempted ren_busy cycle adds at least one cycle. A preemption during DATA re-runs ADDR.
- cpu_busy rises in the cycle after cpu_req and falls in the cycle after ACK. The earliest next accepted cpu_req is the cycle after ACK.
- The mirror_v change takes effect on the next decoded access; there is no pipelining.

## Test plan
- Reset low for 3 cycles, release: all outputs at their reset values. CPU write 0x2005 ← 0xA5 with ren_busy = 0: ADDR cycle shows mem_sel 01, mem_addr 0x005, mem_we 1, mem_wdata 0xA5; cpu_ack 2 cycles after cpu_req.
- Mirroring, each with cpu_rdata returning the same byte:
  - mirror_v = 1: write 0x2400 ← 0x11, read 0x2C00; mem_addr 0x400 both times.
  - mirror_v = 0: write 0x2800 ← 0x22, read 0x2C00; mem_addr 0x400.
- Palette: write 0x3F10 ← 0x0F produces mem_addr 0x00. Write 0x3F11 produces 0x11. Write 0x3F1C produces 0x0C. Read 0x3FE0 produces mem_addr 0x00.
- Preemption: start a CPU read of 0x2001 and raise ren_busy for 4 cycles during DATA. Required: the renderer address is on the bus with mem_we = 0 throughout; the CPU retries ADDR→DATA; cpu_ack arrives 3 cycles after ren_busy falls, with the correct byte.
- Write blocked: ren_busy = 1 on the cpu_req edge and for 2 more cycles. Required: no mem_we pulse until ren_busy falls, then exactly one write.
- CHR_RAM = 0: write 0x0010 is acked with mem_we = 0. A second cpu_req while busy sets cpu_overrun = 1 and does not alter the latched request.

Source files
------------

// File: rtl/ppu_vram_arbiter.sv
// ---------------------------------------------------------------------------
// ppu_vram_arbiter
//
// Shares the single PPU video-memory bus between the scanline renderer's
// fetch port and the CPU-side PPUDATA port, and decodes the 14-bit PPU
// address space into CHR, CIRAM (with nametable mirroring) and palette
// selects. The renderer always wins. CPU accesses are latched, issued only
// while the renderer leaves the bus idle, and retried if they are preempted.
//
// Parameter
//   CHR_RAM      1 = CHR region writable; 0 = CHR writes dropped, still acked
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   ren_busy     renderer owns the bus this cycle
//   ren_addr     renderer VRAM address
//   ren_data     renderer read data (passthrough of mem_rdata)
//   cpu_req      one-cycle CPU request strobe
//   cpu_we       CPU write (1) / read (0), sampled with cpu_req
//   cpu_addr     CPU VRAM address, sampled with cpu_req
//   cpu_wdata    CPU write data, sampled with cpu_req
//   cpu_busy     a CPU request is latched or in flight
//   cpu_ack      one-cycle completion pulse
//   cpu_rdata    last read result, held until the next read completes
//   cpu_overrun  sticky flag: cpu_req arrived while cpu_busy
//   mirror_v     1 = vertical nametable mirroring, 0 = horizontal
//   mem_sel      00 CHR, 01 CIRAM, 10 palette, 11 none
//   mem_addr     physical address inside the selected memory
//   mem_we       memory write enable
//   mem_wdata    memory write data
//   mem_rdata    memory read data, one cycle after the address
// ---------------------------------------------------------------------------
module ppu_vram_arbiter #(
    parameter bit CHR_RAM = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ren_busy,
    input  logic [15:0] ren_addr,
    output logic [7:0]  ren_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_busy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_overrun,
    input  logic        mirror_v,
    output logic [1:0]  mem_sel,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [1:0] SEL_CHR   = 2'b00;
    localparam logic [1:0] SEL_CIRAM = 2'b01;
    localparam logic [1:0] SEL_PAL   = 2'b10;
    localparam logic [1:0] SEL_NONE  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ACK  = 2'b11
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        we_q;
    logic [13:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        overrun_q;

    logic [14:0] ren_dec;
    logic [14:0] cpu_dec;
    logic        cpu_wr_allowed;

    // Address bits 15:14 are outside the PPU address space.
    logic unused_hi;
    assign unused_hi = ^{ren_addr[15:14], cpu_addr[15:14]};

    // Returns {mem_sel, mem_addr} for a 14-bit PPU address.
    function automatic logic [14:0] decode(input logic [13:0] a, input logic mv);
        logic [4:0] p;
        logic       a10;
        logic [14:0] r;
        p   = a[4:0];
        a10 = 1'b0;
        if (!a[13]) begin
            r = {SEL_CHR, a[12:0]};
        end else if (a[13:8] == 6'h3F) begin
            // Sprite-palette entry 0 of each group aliases the background one.
            if (a[4] && (a[1:0] == 2'b00)) begin
                p = {1'b0, a[3:0]};
            end
            r = {SEL_PAL, 8'h00, p};
        end else begin
            // Only two physical nametables; a[11:10] picks one of four logical
            // tables, and mirroring chooses which bit selects the physical one.
            // a[12] is dropped so 0x3000-0x3EFF aliases 0x2000.
            a10 = mv ? a[10] : a[11];
            r = {SEL_CIRAM, 2'b00, a10, a[9:0]};
        end
        return r;
    endfunction

    assign ren_dec = decode(ren_addr[13:0], mirror_v);
    assign cpu_dec = decode(addr_q, mirror_v);
    assign cpu_wr_allowed = we_q && ((cpu_dec[14:13] != SEL_CHR) || CHR_RAM);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched request, read result and overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr[13:0];
                wdata_q <= cpu_wdata;
            end
            // mem_rdata now answers the address driven in the preceding ADDR cycle.
            if ((state_q == ST_DATA) && !ren_busy) begin
                rdata_q <= mem_rdata;
            end
            if (cpu_req && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (!ren_busy) begin
                    state_d = we_q ? ST_ACK : ST_DATA;
                end
            end
            ST_DATA: begin
                // A preempted read lost its memory slot, so the address is re-issued.
                state_d = ren_busy ? ST_ADDR : ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: renderer has unconditional priority on the bus.
    always_comb begin
        mem_sel   = SEL_NONE;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_busy  = (state_q != ST_IDLE);
        cpu_ack   = (state_q == ST_ACK);
        if (ren_busy) begin
            mem_sel  = ren_dec[14:13];
            mem_addr = ren_dec[12:0];
        end else begin
            case (state_q)
                ST_ADDR: begin
                    mem_sel   = cpu_dec[14:13];
                    mem_addr  = cpu_dec[12:0];
                    mem_we    = cpu_wr_allowed;
                    mem_wdata = wdata_q;
                end
                ST_DATA: begin
                    mem_sel  = cpu_dec[14:13];
                    mem_addr = cpu_dec[12:0];
                end
                default: begin
                    mem_sel = SEL_NONE;
                end
            endcase
        end
    end

    assign ren_data    = mem_rdata;
    assign cpu_rdata   = rdata_q;
    assign cpu_overrun = overrun_q;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ppu_vram_arbiter
//
// Drives the arbiter with directed and randomized CPU/renderer traffic. A
// reference model (arithmetic address decode plus a flat byte store) computes
// the expected bus address, write count and read data of every CPU request
// and pushes them into a queue; a monitor on the falling edge pops and
// compares on each cpu_ack, and checks the renderer's bus ownership.
// ---------------------------------------------------------------------------
module tb_ppu_vram_arbiter;

    localparam bit CHR_RAM = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ren_busy = 1'b0;
    logic [15:0] ren_addr = 16'h0000;
    logic [7:0]  ren_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_overrun;
    logic        mirror_v = 1'b0;
    logic [1:0]  mem_sel;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    ppu_vram_arbiter #(.CHR_RAM(CHR_RAM)) dut (
        .clk         (clk),
        .reset       (reset),
        .ren_busy    (ren_busy),
        .ren_addr    (ren_addr),
        .ren_data    (ren_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_busy    (cpu_busy),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .cpu_overrun (cpu_overrun),
        .mirror_v    (mirror_v),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical memories with one-cycle synchronous read.
    bit [7:0] phys_chr   [8192];
    bit [7:0] phys_ciram [2048];
    bit [7:0] phys_pal   [32];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_sel)
                2'b00:   phys_chr[mem_addr] <= mem_wdata;
                2'b01:   phys_ciram[mem_addr[10:0]] <= mem_wdata;
                2'b10:   phys_pal[mem_addr[4:0]] <= mem_wdata;
                default: ;
            endcase
        end
        case (mem_sel)
            2'b00:   mem_rdata <= phys_chr[mem_addr];
            2'b01:   mem_rdata <= phys_ciram[mem_addr[10:0]];
            2'b10:   mem_rdata <= phys_pal[mem_addr[4:0]];
            default: mem_rdata <= 8'h00;
        endcase
    end

    // Reference model: flat store indexed by sel*8192 + physical address.
    bit [7:0] ref_mem [24576];

    function automatic void ref_decode(input logic [15:0] a, input logic mv,
                                       output logic [1:0] sel, output logic [12:0] pa);
        int x, off, tbl, bank, p;
        x = int'(a) % 16384;
        if (x < 8192) begin
            sel = 2'd0;
            pa  = 13'(x);
        end else if (x < 16128) begin
            off  = (x - 8192) % 4096;
            tbl  = off / 1024;
            bank = mv ? (tbl % 2) : (tbl / 2);
            sel  = 2'd1;
            pa   = 13'(bank * 1024 + off % 1024);
        end else begin
            p = x % 32;
            if (p >= 16 && p % 4 == 0) p = p - 16;
            sel = 2'd2;
            pa  = 13'(p);
        end
    endfunction

    typedef struct {
        bit         we;
        logic [1:0] sel;
        logic [12:0] pa;
        logic [7:0] wd;
        logic [7:0] rd;
        int         nwr;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor
    logic [1:0]  bus_sel;
    logic [12:0] bus_addr;
    logic [7:0]  bus_wd;
    bit          bus_seen = 1'b0;
    int          bus_nwr = 0;
    logic [1:0]  mon_rsel;
    logic [12:0] mon_rpa;
    exp_t        mon_e;

    always @(negedge clk) begin
        if (reset) begin
            if (ren_busy) begin
                ref_decode(ren_addr, mirror_v, mon_rsel, mon_rpa);
                check("ren_bus", {mem_sel, mem_addr, mem_we}, {mon_rsel, mon_rpa, 1'b0});
                check("ren_data", ren_data, mem_rdata);
            end else if (mem_sel != 2'b11) begin
                bus_seen = 1'b1;
                bus_sel  = mem_sel;
                bus_addr = mem_addr;
                if (mem_we) begin
                    bus_nwr++;
                    bus_wd = mem_wdata;
                end
            end
            if (cpu_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with empty queue expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("bus_addr", {bus_seen, bus_sel, bus_addr}, {1'b1, mon_e.sel, mon_e.pa});
                    check("write_count", bus_nwr, mon_e.nwr);
                    if (mon_e.nwr > 0) check("write_data", bus_wd, mon_e.wd);
                    if (!mon_e.we) check("read_data", cpu_rdata, mon_e.rd);
                    $display("ack we=%0d sel=%0d pa=0x%03h wd=0x%02h rd=0x%02h nwr=%0d",
                             mon_e.we, mon_e.sel, mon_e.pa, mon_e.wd, cpu_rdata, bus_nwr);
                end
                bus_seen = 1'b0;
                bus_nwr  = 0;
            end
        end
    end

    // Stimulus
    task automatic drive_ren(input int k, input int bstart, input int blen, input bit rnd);
        if (rnd) ren_busy = ($urandom_range(0, 3) == 0);
        else     ren_busy = (k >= bstart) && (k < bstart + blen);
        ren_addr = 16'($urandom);
    endtask

    task automatic push_exp(input bit we, input logic [15:0] a, input logic [7:0] d, input bit mv);
        exp_t e;
        int idx;
        e.we = we;
        ref_decode(a, mv, e.sel, e.pa);
        idx  = int'(e.sel) * 8192 + int'(e.pa);
        e.wd = d;
        e.rd = ref_mem[idx];
        e.nwr = (we && (e.sel != 2'd0 || CHR_RAM)) ? 1 : 0;
        if (e.nwr > 0) ref_mem[idx] = d;
        exp_q.push_back(e);
    endtask

    task automatic access(input bit we, input logic [15:0] a, input logic [7:0] d, input bit mv,
                          input int bstart, input int blen, input bit rnd, input int exp_lat,
                          input string tag);
        int lat;
        @(posedge clk); #1;
        mirror_v  = mv;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        drive_ren(0, bstart, blen, rnd);
        push_exp(we, a, d, mv);
        lat = 0;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            cpu_req = 1'b0;
            drive_ren(k, bstart, blen, rnd);
            @(negedge clk);
            if (k == 1) check({tag, "_busy"}, cpu_busy, 1);
            if (cpu_ack) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack in 64 cycles expected ack", tag);
        end else if (exp_lat > 0) begin
            check({tag, "_latency"}, lat, exp_lat);
        end
        @(posedge clk); #1;
        ren_busy = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, cpu_busy, 0);
    endtask

    initial begin
        logic [15:0] a;
        int region;
        bit [7:0] v;
        int lat;

        for (int i = 0; i < 8192; i++) begin
            v = 8'($urandom);
            phys_chr[i] = v;
            ref_mem[i]  = v;
        end

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {cpu_busy, cpu_ack, cpu_rdata, cpu_overrun, mem_we, mem_sel, mem_addr, mem_wdata},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 13'h0000, 8'h00});
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_outputs",
              {cpu_busy, cpu_ack, cpu_rdata, cpu_overrun, mem_we, mem_sel, mem_addr, mem_wdata},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 13'h0000, 8'h00});

        // Uncontended write / read latency
        access(1'b1, 16'h2005, 8'hA5, 1'b0, 0, 0, 1'b0, 2, "wr_2005");
        access(1'b0, 16'h2005, 8'h00, 1'b0, 0, 0, 1'b0, 3, "rd_2005");

        // Mirroring
        access(1'b1, 16'h2400, 8'h11, 1'b1, 0, 0, 1'b0, 2, "wr_2400_v");
        access(1'b0, 16'h2C00, 8'h00, 1'b1, 0, 0, 1'b0, 3, "rd_2c00_v");
        access(1'b1, 16'h2800, 8'h22, 1'b0, 0, 0, 1'b0, 2, "wr_2800_h");
        access(1'b0, 16'h2C00, 8'h00, 1'b0, 0, 0, 1'b0, 3, "rd_2c00_h");
        access(1'b0, 16'h3400, 8'h00, 1'b1, 0, 0, 1'b0, 3, "rd_3400_alias");

        // Palette aliasing
        access(1'b1, 16'h3F10, 8'h0F, 1'b0, 0, 0, 1'b0, 2, "wr_3f10");
        access(1'b1, 16'h3F11, 8'h21, 1'b0, 0, 0, 1'b0, 2, "wr_3f11");
        access(1'b1, 16'h3F1C, 8'h3C, 1'b0, 0, 0, 1'b0, 2, "wr_3f1c");
        access(1'b0, 16'h3FE0, 8'h00, 1'b0, 0, 0, 1'b0, 3, "rd_3fe0");
        access(1'b0, 16'hFF0C, 8'h00, 1'b0, 0, 0, 1'b0, 3, "rd_ff0c");

        // Read preempted during DATA for 4 cycles: ADDR retried, ack 3 cycles after release
        access(1'b1, 16'h2001, 8'h3C, 1'b0, 0, 0, 1'b0, 2, "wr_2001");
        access(1'b0, 16'h2001, 8'h00, 1'b0, 2, 4, 1'b0, 8, "rd_2001_preempt");

        // Write blocked on the request edge and for 2 more cycles
        access(1'b1, 16'h3F05, 8'h77, 1'b0, 0, 3, 1'b0, 4, "wr_blocked");

        // CHR write dropped; second request while busy sets overrun and is discarded
        check("overrun_clear", cpu_overrun, 0);
        @(posedge clk); #1;
        mirror_v = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
        push_exp(1'b1, 16'h0010, 8'h5A, 1'b0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2123; cpu_wdata = 8'hFF;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        lat = 0;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        check("chr_wr_latency", lat, 2);
        check("overrun_set", cpu_overrun, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("chr_wr_idle", cpu_busy, 0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            region = $urandom_range(0, 3);
            a = 16'($urandom);
            case (region)
                0:       a[13] = 1'b0;
                1, 2:    a[13:0] = 14'(16'h2000 + ((16'($urandom) % 16'h1F00) & 16'h1C0F));
                default: a[13:0] = 14'(16'h3F00 + ($urandom % 256));
            endcase
            access(1'($urandom), a, 8'($urandom), 1'($urandom), 0, 0, 1'b1, 0, "rand");
        end
        check("overrun_sticky", cpu_overrun, 1);
        check("queue_empty", exp_q.size(), 0);

        // Reset in the middle of an access abandons it without an ack
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2001;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_state", {cpu_busy, cpu_overrun, mem_sel}, {1'b0, 1'b0, 2'b11});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_reset_no_ack", cpu_ack, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("after_reset_idle", {cpu_busy, cpu_ack}, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
